// File: rtl/pwm_capture_16bits_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_capture_16bits_pkg: shared widths, enums and helpers for capture  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package pwm_capture_16bits_pkg;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int DIVCLK_WIDTH   = 8;
  localparam int EVTCOUNT_WIDTH = 8;

  typedef enum logic {START_RISE = 1'b0, START_FALL = 1'b1} capt_edge_e;
  typedef enum logic {CAPT_OFF = 1'b0, CAPT_ON = 1'b1}      capt_onoff_e;
  typedef enum logic {CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1}  clkdiv_onoff_e;
  typedef enum logic {INT_OFF = 1'b0, INT_ON = 1'b1}        int_onoff_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } capt_state_e;

  // An event count of zero behaves as one period per interrupt.
  function automatic logic [EVTCOUNT_WIDTH-1:0] evt_limit(input logic [EVTCOUNT_WIDTH-1:0] n);
    return (n == '0) ? EVTCOUNT_WIDTH'(1) : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_16bits_capt_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | capt_tick_gen: prescaler producing a clock-enable tick, with restart  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module capt_tick_gen
  import pwm_capture_16bits_pkg::*;
#(
  parameter int DIV_W = DIVCLK_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             div_on_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] cur;
  logic             wrap;

  // The restart cycle itself counts as prescaler phase 0.
  always_comb begin
    cur       = restart_i ? '0 : div_cnt_q;
    wrap      = (cur == div_i);
    tick_o    = en_i & (~div_on_i | wrap);
    div_cnt_d = (!en_i || !div_on_i || wrap) ? '0 : cur + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_capture_16bits.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_capture_16bits: PWM input capture, period/high width measurement  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pwm_capture_16bits
  import pwm_capture_16bits_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = PWMCOUNT_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      pwm_i,
  input  logic                      capt_onoff_i,
  input  logic                      capt_edge_i,
  input  logic [DIVCLK_WIDTH-1:0]   clkdivider_i,
  input  logic                      clkdiv_onoff_i,
  input  logic [EVTCOUNT_WIDTH-1:0] eventcount_i,
  input  logic                      int_onoff_i,
  output logic [CNT_W-1:0]          period_meas_o,
  output logic [CNT_W-1:0]          high_meas_o,
  output logic                      valid_o,
  output logic                      overflow_o,
  output logic                      capt_irq_o
);

  capt_state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       prev_q;
  capt_edge_e                 edge_sh_q, edge_sh_d;
  logic [DIVCLK_WIDTH-1:0]    div_sh_q, div_sh_d;
  clkdiv_onoff_e              divon_sh_q, divon_sh_d;
  logic [EVTCOUNT_WIDTH-1:0]  evtn_sh_q, evtn_sh_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic [CNT_W-1:0]           high_sh_q, high_sh_d;
  logic [CNT_W-1:0]           period_q, period_d;
  logic [CNT_W-1:0]           high_q, high_d;
  logic                       ovf_out_q, ovf_out_d;
  logic                       valid_q, valid_d;
  logic                       irq_q, irq_d;
  logic [EVTCOUNT_WIDTH-1:0]  evt_q, evt_d, evt_next;

  logic on, pol, norm, norm_prev, start_edge, stop_edge, restart, tick;

  // Both current and previous samples use the same shadowed polarity,
  // so a polarity change while idle never looks like an edge.
  always_comb begin
    on         = (capt_onoff_i == CAPT_ON);
    pol        = (edge_sh_q == START_FALL);
    norm       = sync_q[SYNC_STAGES-1] ^ pol;
    norm_prev  = prev_q ^ pol;
    start_edge = norm & ~norm_prev;
    stop_edge  = ~norm & norm_prev;
    restart    = on && start_edge && (state_q == ARM || state_q == LOW);
  end

  capt_tick_gen #(
    .DIV_W (DIVCLK_WIDTH)
  ) u_tick (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (on && (state_q != IDLE)),
    .restart_i (restart),
    .div_on_i  (divon_sh_q == CLKDIV_ON),
    .div_i     (div_sh_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d    = state_q;
    edge_sh_d  = edge_sh_q;
    div_sh_d   = div_sh_q;
    divon_sh_d = divon_sh_q;
    evtn_sh_d  = evtn_sh_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    high_sh_d  = high_sh_q;
    period_d   = period_q;
    high_d     = high_q;
    ovf_out_d  = ovf_out_q;
    valid_d    = 1'b0;
    irq_d      = 1'b0;
    evt_d      = evt_q;
    evt_next   = evt_q + 1'b1;

    if (state_q == IDLE || restart) begin
      edge_sh_d  = capt_edge_e'(capt_edge_i);
      div_sh_d   = clkdivider_i;
      divon_sh_d = clkdiv_onoff_e'(clkdiv_onoff_i);
      evtn_sh_d  = eventcount_i;
    end

    if (restart) begin
      cnt_d = tick ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (state_q == HIGH || state_q == LOW) begin
      if (tick) begin
        if (cnt_q == '1) ovf_d = 1'b1;
        else             cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    if (!on) begin
      state_d = IDLE;
      evt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM:  if (start_edge) state_d = HIGH;
        HIGH: begin
          if (stop_edge) begin
            high_sh_d = cnt_q;
            state_d   = LOW;
          end
        end
        LOW: begin
          if (start_edge) begin
            period_d  = cnt_q;
            high_d    = high_sh_q;
            ovf_out_d = ovf_q;
            valid_d   = 1'b1;
            if (evt_next >= evt_limit(evtn_sh_q)) begin
              evt_d = '0;
              irq_d = (int_onoff_i == INT_ON);
            end else begin
              evt_d = evt_next;
            end
            state_d = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_sh_q  <= START_RISE;
      div_sh_q   <= '0;
      divon_sh_q <= CLKDIV_OFF;
      evtn_sh_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      high_sh_q  <= '0;
      period_q   <= '0;
      high_q     <= '0;
      ovf_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      irq_q      <= 1'b0;
      evt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_sh_q  <= edge_sh_d;
      div_sh_q   <= div_sh_d;
      divon_sh_q <= divon_sh_d;
      evtn_sh_q  <= evtn_sh_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      high_sh_q  <= high_sh_d;
      period_q   <= period_d;
      high_q     <= high_d;
      ovf_out_q  <= ovf_out_d;
      valid_q    <= valid_d;
      irq_q      <= irq_d;
      evt_q      <= evt_d;
    end
  end

  assign period_meas_o = period_q;
  assign high_meas_o   = high_q;
  assign valid_o       = valid_q;
  assign overflow_o    = ovf_out_q;
  assign capt_irq_o    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture_16bits.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pwm_capture_16bits: scoreboard bench for the PWM capture unit      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_pwm_capture_16bits;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pwm_i = 1'b0;
  logic        capt_onoff_i = 1'b0;
  logic        capt_edge_i = 1'b0;
  logic [7:0]  clkdivider_i = '0;
  logic        clkdiv_onoff_i = 1'b0;
  logic [7:0]  eventcount_i = '0;
  logic        int_onoff_i = 1'b0;
  logic [15:0] period_meas_o;
  logic [15:0] high_meas_o;
  logic        valid_o;
  logic        overflow_o;
  logic        capt_irq_o;

  pwm_capture_16bits dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pwm_i          (pwm_i),
    .capt_onoff_i   (capt_onoff_i),
    .capt_edge_i    (capt_edge_i),
    .clkdivider_i   (clkdivider_i),
    .clkdiv_onoff_i (clkdiv_onoff_i),
    .eventcount_i   (eventcount_i),
    .int_onoff_i    (int_onoff_i),
    .period_meas_o  (period_meas_o),
    .high_meas_o    (high_meas_o),
    .valid_o        (valid_o),
    .overflow_o     (overflow_o),
    .capt_irq_o     (capt_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int per;
    int hi;
    bit ovf;
    bit irq;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_v   = 0;
  int   bench_evt = 0;
  bit   inv = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(valid_o), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("period_meas", 32'(period_meas_o), 32'(e.per));
          chk("high_meas",   32'(high_meas_o),   32'(e.hi));
          chk("overflow",    32'(overflow_o),    32'(e.ovf));
          chk("capt_irq",    32'(capt_irq_o),    32'(e.irq));
          if (e.gap != 0) chk("valid_gap", 32'(cyc - last_v), 32'(e.gap));
        end
        last_v = cyc;
      end else if (capt_irq_o) begin
        chk("irq_without_valid", 32'(capt_irq_o), 32'd0);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_line(input bit norm);
    pwm_i = norm ^ inv;
  endtask

  task automatic push(input int per, input int hi, input bit ovf, input int gap);
    exp_t e;
    int   lim;
    lim = (eventcount_i == 0) ? 1 : int'(eventcount_i);
    bench_evt++;
    e.irq = 1'b0;
    if (bench_evt >= lim) begin
      bench_evt = 0;
      e.irq = int_onoff_i;
    end
    e.per = per;
    e.hi  = hi;
    e.ovf = ovf;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Drives n+1 active phases; start edges 1..n close a measured period.
  task automatic burst(input int hi, input int per, input int n,
                       input int exp_hi, input int exp_per, input int gap);
    for (int p = 0; p <= n; p++) begin
      if (p > 0) push(exp_per, exp_hi, 1'b0, (p > 1) ? gap : 0);
      set_line(1'b1);
      wait_clk(hi);
      set_line(1'b0);
      wait_clk(per - hi);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      wait_clk(1);
    end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic enable();
    wait_clk(3);
    capt_onoff_i = 1'b1;
    wait_clk(4);
  endtask

  task automatic disable_capt();
    capt_onoff_i = 1'b0;
    bench_evt = 0;
    wait_clk(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(4);
    chk("reset_period", 32'(period_meas_o), 32'd0);
    chk("reset_high",   32'(high_meas_o),   32'd0);
    chk("reset_valid",  32'(valid_o),       32'd0);
    chk("reset_ovf",    32'(overflow_o),    32'd0);
    chk("reset_irq",    32'(capt_irq_o),    32'd0);
    rst_ni = 1'b1;

    // No prescaler, rising start, 30/100, irq every 4th valid.
    inv = 1'b0; capt_edge_i = 1'b0; clkdiv_onoff_i = 1'b0;
    eventcount_i = 8'd4; int_onoff_i = 1'b1;
    set_line(1'b0);
    enable();
    burst(30, 100, 8, 30, 100, 100);
    drain("drain_basic");
    disable_capt();

    // Prescaler /4: 400-clk period, 100-clk high, irq disabled.
    clkdiv_onoff_i = 1'b1; clkdivider_i = 8'd3;
    eventcount_i = 8'd0; int_onoff_i = 1'b0;
    enable();
    burst(100, 400, 3, 25, 100, 400);
    drain("drain_prescale");
    disable_capt();

    // Falling start; enabling mid-active phase must skip that partial period.
    clkdiv_onoff_i = 1'b0; inv = 1'b1; capt_edge_i = 1'b1;
    eventcount_i = 8'd0; int_onoff_i = 1'b1;
    set_line(1'b0);
    wait_clk(3);
    set_line(1'b1);
    enable();
    wait_clk(10);
    set_line(1'b0);
    wait_clk(15);
    burst(20, 50, 3, 20, 50, 50);
    drain("drain_fall");
    disable_capt();

    // Capture dropped mid-HIGH then re-enabled.
    inv = 1'b0; capt_edge_i = 1'b0; set_line(1'b0);
    eventcount_i = 8'd4; int_onoff_i = 1'b1;
    enable();
    burst(30, 100, 2, 30, 100, 100);
    push(100, 30, 1'b0, 100);
    set_line(1'b1);
    wait_clk(10);
    drain("drain_pre_off");
    disable_capt();
    wait_clk(20);
    set_line(1'b0);
    wait_clk(70);
    set_line(1'b1);
    wait_clk(10);
    chk("hold_period", 32'(period_meas_o), 32'd100);
    chk("hold_high",   32'(high_meas_o),   32'd30);
    capt_onoff_i = 1'b1;
    wait_clk(10);
    set_line(1'b0);
    wait_clk(70);
    burst(30, 100, 4, 30, 100, 100);
    drain("drain_reenable");
    disable_capt();

    // Stuck line: counter saturates, first valid flags overflow.
    eventcount_i = 8'd0; int_onoff_i = 1'b0;
    enable();
    set_line(1'b1);
    wait_clk(70000);
    set_line(1'b0);
    wait_clk(50);
    push(16'hFFFF, 16'hFFFF, 1'b1, 0);
    burst(30, 100, 2, 30, 100, 100);
    drain("drain_stuck");

    // Asynchronous reset while in LOW clears outputs immediately.
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("areset_period", 32'(period_meas_o), 32'd0);
    chk("areset_high",   32'(high_meas_o),   32'd0);
    chk("areset_valid",  32'(valid_o),       32'd0);
    chk("areset_ovf",    32'(overflow_o),    32'd0);
    bench_evt = 0;
    wait_clk(3);
    rst_ni = 1'b1;
    wait_clk(5);
    burst(30, 100, 1, 30, 100, 0);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
